// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH -> EXEC1 -> (EXEC2) with STP halt, resume, single-step and stall.
// Optional retired-instruction / cycle counters are built only when SEQ_PERF_COUNTERS_EN is defined.
module cpu_sequencer #(
    parameter logic [5:0] STP_OPCODE = 6'd39,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sm_extra,
    input  logic [5:0]       encoded_opcode,
    input  logic             stall,
    input  logic             resume,
    input  logic             step_mode,
    input  logic             cnt_clr,
    output logic [1:0]       state,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    // Encodings are fixed by the instruction decoder that consumes `state`.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC1 = 2'b10,
        EXEC2 = 2'b01,
        HALT  = 2'b11
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;
    logic       retire_d;

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        if (!stall) begin
            case (state_q)
                FETCH: state_d = EXEC1;
                EXEC1: begin
                    if (encoded_opcode == STP_OPCODE) begin
                        state_d  = HALT;
                        retire_d = 1'b1;
                    end else if (sm_extra) begin
                        state_d = EXEC2;
                    end else begin
                        state_d  = step_mode ? HALT : FETCH;
                        retire_d = 1'b1;
                    end
                end
                EXEC2: begin
                    state_d  = step_mode ? HALT : FETCH;
                    retire_d = 1'b1;
                end
                HALT:    if (resume) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state  = state_q;
    assign halted = (state_q == HALT);
    // Reset wins over a completing instruction in the same cycle.
    assign retire = retire_d && !reset;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] cycle_q;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            if (retire_d)                  instr_q <= instr_q + CNT_W'(1);
            if (!stall && state_q != HALT) cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign instr_count    = '0;
    assign cycle_count    = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (CNT_W=4 so counter wrap is reachable quickly).
// Counter expectations collapse to 0 when SEQ_PERF_COUNTERS_EN is not defined.
module tb_cpu_sequencer;

    localparam int CNT_W = 4;
`ifdef SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, sm_extra, stall, resume, step_mode, cnt_clr;
    logic [5:0]       encoded_opcode;
    logic [1:0]       state;
    logic             halted, retire;
    logic [CNT_W-1:0] instr_count, cycle_count;

    int checks = 0;
    int passed = 0;
    logic [CNT_W-1:0] exp_i = '0;
    logic [CNT_W-1:0] exp_c = '0;

    cpu_sequencer #(.STP_OPCODE(6'd39), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sm_extra(sm_extra), .encoded_opcode(encoded_opcode),
        .stall(stall), .resume(resume), .step_mode(step_mode), .cnt_clr(cnt_clr),
        .state(state), .halted(halted), .retire(retire),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sm_extra = 1'b0; encoded_opcode = 6'd0; stall = 1'b0;
        resume = 1'b0; step_mode = 1'b0; cnt_clr = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'b00) $display("FAIL reset_state got=%b exp=00", state); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passed++;
        checks++; if (retire !== 1'b0) $display("FAIL reset_retire got=%b exp=0", retire); else passed++;
        checks++; if (instr_count !== 4'd0) $display("FAIL reset_instr got=%0d exp=0", instr_count); else passed++;
        checks++; if (cycle_count !== 4'd0) $display("FAIL reset_cycle got=%0d exp=0", cycle_count); else passed++;
    endtask

    task automatic test_add();
        logic [1:0] es [3];
        logic       er [3];
        es = '{2'b00, 2'b10, 2'b00};
        er = '{1'b0, 1'b1, 1'b0};
        sm_extra = 1'b0; encoded_opcode = 6'd17;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (state !== es[i]) $display("FAIL add_state[%0d] got=%b exp=%b", i, state, es[i]); else passed++;
            checks++; if (retire !== er[i]) $display("FAIL add_retire[%0d] got=%b exp=%b", i, retire, er[i]); else passed++;
            if (i < 2) cyc();
        end
        exp_i += 4'd1; exp_c += 4'd2;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL add_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL add_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
    endtask

    task automatic test_lda();
        logic [1:0] es [4];
        logic       er [4];
        es = '{2'b00, 2'b10, 2'b01, 2'b00};
        er = '{1'b0, 1'b0, 1'b1, 1'b0};
        sm_extra = 1'b1; encoded_opcode = 6'd37;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== es[i]) $display("FAIL lda_state[%0d] got=%b exp=%b", i, state, es[i]); else passed++;
            checks++; if (retire !== er[i]) $display("FAIL lda_retire[%0d] got=%b exp=%b", i, retire, er[i]); else passed++;
            if (i < 3) cyc();
        end
        exp_i += 4'd1; exp_c += 4'd3;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL lda_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL lda_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
    endtask

    task automatic test_stp();
        sm_extra = 1'b1; encoded_opcode = 6'd39;
        cyc();
        checks++; if (state !== 2'b10 || retire !== 1'b1) $display("FAIL stp_exec1 got=%b/%b exp=10/1", state, retire); else passed++;
        cyc();
        exp_i += 4'd1; exp_c += 4'd2;
        checks++; if (state !== 2'b11) $display("FAIL stp_halt_state got=%b exp=11", state); else passed++;
        checks++; if (halted !== 1'b1) $display("FAIL stp_halted got=%b exp=1", halted); else passed++;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL stp_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (state !== 2'b11 || retire !== 1'b0) $display("FAIL stp_hold[%0d] got=%b/%b exp=11/0", i, state, retire); else passed++;
        end
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL stp_cycle_frozen got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
        resume = 1'b1;
        #1;
        checks++; if (retire !== 1'b0) $display("FAIL stp_resume_retire got=%b exp=0", retire); else passed++;
        cyc();
        resume = 1'b0;
        checks++; if (state !== 2'b00 || halted !== 1'b0) $display("FAIL stp_resumed got=%b/%b exp=00/0", state, halted); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL stp_resume_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
    endtask

    task automatic test_step_mode();
        step_mode = 1'b1; sm_extra = 1'b0; encoded_opcode = 6'd17;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (state !== 2'b00) $display("FAIL step_fetch[%0d] got=%b exp=00", k, state); else passed++;
            cyc();
            resume = 1'b1;
            #1;
            checks++; if (state !== 2'b10 || retire !== 1'b1) $display("FAIL step_exec1[%0d] got=%b/%b exp=10/1", k, state, retire); else passed++;
            cyc();
            resume = 1'b0;
            exp_i += 4'd1; exp_c += 4'd2;
            checks++; if (state !== 2'b11) $display("FAIL step_halt[%0d] got=%b exp=11", k, state); else passed++;
            cyc();
            checks++; if (state !== 2'b11) $display("FAIL step_stay[%0d] got=%b exp=11", k, state); else passed++;
            resume = 1'b1;
            cyc();
            resume = 1'b0;
        end
        step_mode = 1'b0;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL step_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL step_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
    endtask

    task automatic test_stall();
        sm_extra = 1'b1; encoded_opcode = 6'd37;
        cyc(); cyc();
        exp_c += 4'd2;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== 2'b01 || retire !== 1'b0) $display("FAIL stall_hold[%0d] got=%b/%b exp=01/0", i, state, retire); else passed++;
            cyc();
        end
        checks++; if (state !== 2'b01) $display("FAIL stall_state got=%b exp=01", state); else passed++;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL stall_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL stall_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
        stall = 1'b0;
        #1;
        checks++; if (retire !== 1'b1) $display("FAIL stall_release_retire got=%b exp=1", retire); else passed++;
        cyc();
        exp_i += 4'd1; exp_c += 4'd1;
        checks++; if (state !== 2'b00) $display("FAIL stall_release_state got=%b exp=00", state); else passed++;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL stall_release_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL stall_release_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
        // Reset while an instruction sits in EXEC2
        cyc(); cyc();
        checks++; if (state !== 2'b01) $display("FAIL rst_mid_pre got=%b exp=01", state); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (retire !== 1'b0) $display("FAIL rst_mid_retire got=%b exp=0", retire); else passed++;
        cyc();
        reset = 1'b0;
        exp_i = '0; exp_c = '0;
        checks++; if (state !== 2'b00) $display("FAIL rst_mid_state got=%b exp=00", state); else passed++;
        checks++; if (instr_count !== 4'd0 || cycle_count !== 4'd0) $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", instr_count, cycle_count); else passed++;
    endtask

    task automatic test_wrap_clear();
        sm_extra = 1'b0; encoded_opcode = 6'd17;
        for (int n = 1; n <= 16; n++) begin
            cyc(); cyc();
            exp_i += 4'd1; exp_c += 4'd2;
            if (n >= 15) begin
                checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL wrap_instr[%0d] got=%0d exp=%0d", n, instr_count, PERF ? exp_i : 4'd0); else passed++;
                checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL wrap_cycle[%0d] got=%0d exp=%0d", n, cycle_count, PERF ? exp_c : 4'd0); else passed++;
            end
        end
        cyc();
        cnt_clr = 1'b1;
        #1;
        checks++; if (retire !== 1'b1) $display("FAIL clr_retire got=%b exp=1", retire); else passed++;
        cyc();
        cnt_clr = 1'b0;
        exp_i = '0; exp_c = '0;
        checks++; if (state !== 2'b00) $display("FAIL clr_state got=%b exp=00", state); else passed++;
        checks++; if (instr_count !== 4'd0 || cycle_count !== 4'd0) $display("FAIL clr_counts got=%0d/%0d exp=0/0", instr_count, cycle_count); else passed++;
        cyc(); cyc();
        exp_i += 4'd1; exp_c += 4'd2;
        checks++; if (instr_count !== (PERF ? exp_i : 4'd0)) $display("FAIL post_clr_instr got=%0d exp=%0d", instr_count, PERF ? exp_i : 4'd0); else passed++;
        checks++; if (cycle_count !== (PERF ? exp_c : 4'd0)) $display("FAIL post_clr_cycle got=%0d exp=%0d", cycle_count, PERF ? exp_c : 4'd0); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lda();
        test_stp();
        test_step_mode();
        test_stall();
        test_wrap_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1);
    end

endmodule
